// File: rtl/sdram_arbiter_if.sv
// Controller-side bus between sdram_arbiter and the single-channel sdram controller.
//
// Handshake: rd_req/wr_req rise with address, length and write data already
// stable, and they stay high and unchanged until the controller pulses the
// matching rd_ack/wr_ack for one cycle. The request is dropped on the cycle
// after that ack. rd_rdy is a one-cycle strobe that qualifies rd_data. It has
// no back-pressure, so the arbiter must always accept returned words.
interface sdram_arbiter_if #(
   parameter int XWIDTH = 20,
   parameter int DWIDTH = 16
);
   logic [XWIDTH-1:0] rd_addr;
   logic [3:0]        rd_len;
   logic              rd_req;
   logic              rd_ack;
   logic [DWIDTH-1:0] rd_data;
   logic              rd_rdy;
   logic [XWIDTH-1:0] wr_addr;
   logic [DWIDTH-1:0] wr_data;
   logic [3:0]        wr_len;
   logic              wr_req;
   logic              wr_ack;

   // The arbiter drives requests.
   modport master (
      output rd_addr, rd_len, rd_req, wr_addr, wr_data, wr_len, wr_req,
      input  rd_ack, rd_data, rd_rdy, wr_ack
   );

   // The controller answers with acks and read data.
   modport slave (
      input  rd_addr, rd_len, rd_req, wr_addr, wr_data, wr_len, wr_req,
      output rd_ack, rd_data, rd_rdy, wr_ack
   );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter that shares one sdram controller among NPORTS clients.
// Outstanding read bursts are tracked in a tag FIFO of {port, len} entries.
// Returned words are steered back to the port at the FIFO head.
module sdram_arbiter #(
   parameter int NPORTS   = 4,
   parameter int XWIDTH   = 20,
   parameter int DWIDTH   = 16,
   parameter int TAGDEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NPORTS-1:0]        p_req,
   input  logic [NPORTS-1:0]        p_we,
   input  logic [NPORTS*XWIDTH-1:0] p_addr,
   input  logic [NPORTS*4-1:0]      p_len,
   input  logic [NPORTS*DWIDTH-1:0] p_wdata,
   output logic [NPORTS-1:0]        p_ack,
   output logic [DWIDTH-1:0]        p_rdata,
   output logic [NPORTS-1:0]        p_rdy,
   output logic                     tag_err,
   output logic [1:0]               dbg_state_o,
   sdram_arbiter_if.master          ctl
);
   localparam int IW = $clog2(NPORTS);
   localparam int TW = $clog2(TAGDEPTH);
   localparam int CW = TW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Per-port views of the packed client buses.
   logic [XWIDTH-1:0] addr_arr  [NPORTS];
   logic [3:0]        len_arr   [NPORTS];
   logic [DWIDTH-1:0] wdata_arr [NPORTS];

   // Arbitration and the latched request.
   logic [NPORTS-1:0] elig;
   logic [IW-1:0]     win;
   logic              win_vld;
   logic              grant;
   logic              ack_hit;
   logic [IW-1:0]     last_q, gnt_q;
   logic              we_q;
   logic [XWIDTH-1:0] addr_q;
   logic [3:0]        len_q;
   logic [DWIDTH-1:0] wdata_q;
   logic              rd_req_q, wr_req_q;
   logic [NPORTS-1:0] p_ack_q;

   // Tag FIFO and read return path.
   logic [IW-1:0]     tag_port_q [TAGDEPTH];
   logic [3:0]        tag_len_q  [TAGDEPTH];
   logic [TW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     cnt_q;
   logic [4:0]        rem_q, rem_eff, rem_dec;
   logic              head_ld_q;
   logic              tags_free;
   logic              push, pop, rdy_hit;
   logic [NPORTS-1:0] p_rdy_q;
   logic [DWIDTH-1:0] p_rdata_q;
   logic              tag_err_q;

   // Unpack the per-port client buses.
   always_comb begin
      for (int i = 0; i < NPORTS; i++) begin
         addr_arr[i]  = p_addr[i*XWIDTH +: XWIDTH];
         len_arr[i]   = p_len[i*4 +: 4];
         wdata_arr[i] = p_wdata[i*DWIDTH +: DWIDTH];
      end
   end

   // Writes are always eligible. Reads must wait for a free tag slot.
   assign tags_free = (cnt_q < CW'(TAGDEPTH));
   assign elig      = p_req & (p_we | {NPORTS{tags_free}});

   // Round-robin search. The search starts one past the last granted port.
   always_comb begin
      logic [IW-1:0] idx;
      win     = '0;
      win_vld = 1'b0;
      idx     = '0;
      for (int i = 1; i <= NPORTS; i++) begin
         idx = IW'((int'(last_q) + i) % NPORTS);
         if (!win_vld && elig[idx]) begin
            win_vld = 1'b1;
            win     = idx;
         end
      end
   end

   // Next-state logic and the grant/ack strobes.
   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      ack_hit = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               grant   = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            ack_hit = we_q ? ctl.wr_ack : ctl.rd_ack;
            if (ack_hit) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Latch the winner on grant, hold the controller request until ack, then pulse p_ack.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q   <= IW'(NPORTS - 1);
         gnt_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         len_q    <= '0;
         wdata_q  <= '0;
         rd_req_q <= 1'b0;
         wr_req_q <= 1'b0;
         p_ack_q  <= '0;
      end else begin
         p_ack_q <= '0;
         if (grant) begin
            gnt_q    <= win;
            last_q   <= win;
            we_q     <= p_we[win];
            addr_q   <= addr_arr[win];
            len_q    <= len_arr[win];
            wdata_q  <= wdata_arr[win];
            rd_req_q <= !p_we[win];
            wr_req_q <= p_we[win];
         end
         if (ack_hit) begin
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            p_ack_q  <= NPORTS'(1) << gnt_q;
         end
      end
   end

   // Head bookkeeping. Before the remaining count is loaded, the head length is used directly.
   // This lets a word that arrives right after a push or pop count correctly.
   always_comb begin
      rem_eff = head_ld_q ? rem_q : ({1'b0, tag_len_q[rd_ptr_q]} + 5'd1);
      rem_dec = rem_eff - 5'd1;
      rdy_hit = ctl.rd_rdy && (cnt_q != '0);
      pop     = rdy_hit && (rem_dec == 5'd0);
      push    = ack_hit && !we_q;
   end

   // Tag storage. Emptiness comes from the pointers and count, so the entries need no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         tag_port_q[wr_ptr_q] <= gnt_q;
         tag_len_q[wr_ptr_q]  <= len_q;
      end
   end

   // Tag FIFO pointers, head remaining count, read steering and the sticky error flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         rem_q     <= '0;
         head_ld_q <= 1'b0;
         p_rdy_q   <= '0;
         p_rdata_q <= '0;
         tag_err_q <= 1'b0;
      end else begin
         p_rdy_q <= '0;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      cnt_q <= cnt_q + 1'b1;
         else if (pop && !push) cnt_q <= cnt_q - 1'b1;

         if (rdy_hit) begin
            p_rdy_q   <= NPORTS'(1) << tag_port_q[rd_ptr_q];
            p_rdata_q <= ctl.rd_data;
            if (pop) begin
               head_ld_q <= 1'b0;
            end else begin
               rem_q     <= rem_dec;
               head_ld_q <= 1'b1;
            end
         end else if ((cnt_q != '0) && !head_ld_q) begin
            rem_q     <= rem_eff;
            head_ld_q <= 1'b1;
         end

         // Data with no owner is dropped, and the error is remembered until reset.
         if (ctl.rd_rdy && (cnt_q == '0)) tag_err_q <= 1'b1;
      end
   end

   assign ctl.rd_addr = addr_q;
   assign ctl.rd_len  = len_q;
   assign ctl.rd_req  = rd_req_q;
   assign ctl.wr_addr = addr_q;
   assign ctl.wr_data = wdata_q;
   assign ctl.wr_len  = len_q;
   assign ctl.wr_req  = wr_req_q;

   assign p_ack       = p_ack_q;
   assign p_rdy       = p_rdy_q;
   assign p_rdata     = p_rdata_q;
   assign tag_err     = tag_err_q;
   assign dbg_state_o = state_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter. It uses a vector table of single transactions,
// then hand-written sequences for round-robin, tag-full, interleave, error and reset.
module tb_sdram_arbiter;
   localparam int NP = 4;
   localparam int XW = 20;
   localparam int DW = 16;
   localparam int TD = 4;

   logic              clk;
   logic              reset_n;
   logic [NP-1:0]     p_req, p_we, p_ack, p_rdy;
   logic [NP*XW-1:0]  p_addr;
   logic [NP*4-1:0]   p_len;
   logic [NP*DW-1:0]  p_wdata;
   logic [DW-1:0]     p_rdata;
   logic              tag_err;
   logic [1:0]        dbg_state;

   sdram_arbiter_if #(.XWIDTH(XW), .DWIDTH(DW)) ctl ();

   sdram_arbiter #(.NPORTS(NP), .XWIDTH(XW), .DWIDTH(DW), .TAGDEPTH(TD)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .p_req       (p_req),
      .p_we        (p_we),
      .p_addr      (p_addr),
      .p_len       (p_len),
      .p_wdata     (p_wdata),
      .p_ack       (p_ack),
      .p_rdata     (p_rdata),
      .p_rdy       (p_rdy),
      .tag_err     (tag_err),
      .dbg_state_o (dbg_state),
      .ctl         (ctl)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   int ack_cnt  [NP] = '{default: 0};
   int ack_snap [NP] = '{default: 0};
   // Expected read return: {cycle p_rdy must appear, port, data}.
   logic [55:0] exp_q[$];
   logic [55:0] mon_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Count p_ack pulses and match every p_rdy pulse against the expected queue.
   always @(negedge clk) begin
      if (reset_n) begin
         for (int i = 0; i < NP; i++) if (p_ack[i]) ack_cnt[i]++;
         if (p_rdy != '0) begin
            if (exp_q.size() == 0) begin
               check("rdy_unexpected", 64'(p_rdy), 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("rdy_port",  64'(p_rdy), 64'd1 << mon_e[23:16]);
               check("rdy_data",  64'(p_rdata), 64'(mon_e[15:0]));
               check("rdy_cycle", 64'(cyc), 64'(mon_e[55:24]));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_idle();
      int n = 0;
      while (dbg_state != 2'd0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("idle_timeout", 64'(n < 50), 64'd1);
   endtask

   task automatic set_req(input int port, input bit we, input logic [XW-1:0] addr,
                          input logic [3:0] len, input logic [DW-1:0] wdata);
      p_we[port]              = we;
      p_addr[port*XW +: XW]   = addr;
      p_len[port*4 +: 4]      = len;
      p_wdata[port*DW +: DW]  = wdata;
      p_req[port]             = 1'b1;
   endtask

   // Act as the controller for one request: check it, ack it, check p_ack, and drop the client request.
   task automatic serve(input int port, input bit we, input logic [XW-1:0] addr,
                        input logic [3:0] len, input logic [DW-1:0] wdata, input int hold);
      int n = 0;
      while (!(ctl.rd_req || ctl.wr_req) && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      check("req_timeout", 64'(n < 60), 64'd1);
      check("req_kind", 64'({ctl.rd_req, ctl.wr_req}), we ? 64'd1 : 64'd2);
      check("req_addr", 64'(we ? ctl.wr_addr : ctl.rd_addr), 64'(addr));
      check("req_len",  64'(we ? ctl.wr_len : ctl.rd_len), 64'(len));
      if (we) check("req_wdata", 64'(ctl.wr_data), 64'(wdata));
      repeat (hold) begin
         @(posedge clk); #1;
      end
      if (hold > 0) check("req_hold", 64'(ctl.rd_req | ctl.wr_req), 64'd1);
      if (we) ctl.wr_ack = 1'b1;
      else    ctl.rd_ack = 1'b1;
      @(posedge clk); #1;
      ctl.wr_ack = 1'b0;
      ctl.rd_ack = 1'b0;
      check("p_ack", 64'(p_ack), 64'd1 << port);
      check("req_drop", 64'({ctl.rd_req, ctl.wr_req}), 64'd0);
      p_req[port] = 1'b0;
   endtask

   // Present one returned word. When valid, its p_rdy is expected exactly one cycle later.
   task automatic ret_word(input int port, input logic [DW-1:0] data, input bit valid);
      ctl.rd_rdy  = 1'b1;
      ctl.rd_data = data;
      if (valid) exp_q.push_back({32'(cyc + 1), 8'(port), data});
      @(posedge clk); #1;
      ctl.rd_rdy = 1'b0;
   endtask

   task automatic snap_acks();
      for (int i = 0; i < NP; i++) ack_snap[i] = ack_cnt[i];
   endtask

   task automatic check_acks(input logic [NP-1:0] mask);
      for (int i = 0; i < NP; i++)
         check($sformatf("ack_count_p%0d", i), 64'(ack_cnt[i] - ack_snap[i]), 64'(mask[i]));
   endtask

   task automatic settle_and_drain(input string name);
      repeat (3) begin
         @(posedge clk); #1;
      end
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int            port;
      bit            we;
      logic [XW-1:0] addr;
      logic [3:0]    len;
      logic [DW-1:0] wdata;
      int            hold;      // cycles the controller delays its ack
      logic [DW-1:0] rbase;     // first returned word for reads (word k = rbase+k)
      logic [1:0]    exp_req;   // {rd_req, wr_req} one cycle after p_req
      logic [NP-1:0] exp_ack;   // p_ack during DONE
   } vec_t;

   vec_t vecs[6];
   vec_t cur;
   int   seen;

   initial begin
      vecs[0] = '{1, 1'b0, 20'h00100, 4'd3,  16'h0000, 0, 16'hA000, 2'b10, 4'b0010};
      vecs[1] = '{0, 1'b1, 20'h12345, 4'd0,  16'hBEEF, 0, 16'h0000, 2'b01, 4'b0001};
      vecs[2] = '{3, 1'b1, 20'hFFFFF, 4'd15, 16'h5A5A, 3, 16'h0000, 2'b01, 4'b1000};
      vecs[3] = '{2, 1'b0, 20'h00000, 4'd0,  16'h0000, 2, 16'h1234, 2'b10, 4'b0100};
      vecs[4] = '{3, 1'b0, 20'h0ABCD, 4'd7,  16'h0000, 1, 16'hFFF0, 2'b10, 4'b1000};
      vecs[5] = '{0, 1'b0, 20'h80000, 4'd1,  16'h0000, 0, 16'h0055, 2'b10, 4'b0001};

      reset_n     = 1'b0;
      p_req       = '0;
      p_we        = '0;
      p_addr      = '0;
      p_len       = '0;
      p_wdata     = '0;
      ctl.rd_ack  = 1'b0;
      ctl.wr_ack  = 1'b0;
      ctl.rd_rdy  = 1'b0;
      ctl.rd_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state",   64'(dbg_state), 64'd0);
      check("rst_reqs",    64'({ctl.rd_req, ctl.wr_req}), 64'd0);
      check("rst_outputs", 64'({p_ack, p_rdy, tag_err}), 64'd0);
      check("rst_rdata",   64'(p_rdata), 64'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Round-robin from reset (last = 3): ports 0, 2 and 3 write together -> order 0, 2, 3.
      wait_idle();
      snap_acks();
      set_req(0, 1'b1, 20'h0A000, 4'd1, 16'hD000);
      set_req(2, 1'b1, 20'h0A002, 4'd2, 16'hD002);
      set_req(3, 1'b1, 20'h0A003, 4'd3, 16'hD003);
      @(posedge clk); #1;
      check("rr_latency", 64'(ctl.wr_req), 64'd1);
      serve(0, 1'b1, 20'h0A000, 4'd1, 16'hD000, 0);
      serve(2, 1'b1, 20'h0A002, 4'd2, 16'hD002, 1);
      serve(3, 1'b1, 20'h0A003, 4'd3, 16'hD003, 0);
      settle_and_drain("rr_drain");
      check_acks(4'b1101);

      // Table-driven single transactions.
      for (int i = 0; i < 6; i++) begin
         cur = vecs[i];
         wait_idle();
         set_req(cur.port, cur.we, cur.addr, cur.len, cur.wdata);
         @(posedge clk); #1;
         check($sformatf("vec%0d_grant", i), 64'({ctl.rd_req, ctl.wr_req}), 64'(cur.exp_req));
         serve(cur.port, cur.we, cur.addr, cur.len, cur.wdata, cur.hold);
         check($sformatf("vec%0d_ack", i), 64'(p_ack), 64'(cur.exp_ack));
         if (!cur.we)
            for (int k = 0; k <= int'(cur.len); k++) ret_word(cur.port, 16'(cur.rbase + 16'(k)), 1'b1);
         settle_and_drain($sformatf("vec%0d_drain", i));
      end

      // Tag full: four len=0 reads are outstanding, so a fifth read stays blocked until one word returns.
      serve_read_setup: begin
         wait_idle(); set_req(0, 1'b0, 20'h00010, 4'd0, 16'h0); serve(0, 1'b0, 20'h00010, 4'd0, 16'h0, 0);
         wait_idle(); set_req(1, 1'b0, 20'h00011, 4'd0, 16'h0); serve(1, 1'b0, 20'h00011, 4'd0, 16'h0, 0);
         wait_idle(); set_req(3, 1'b0, 20'h00013, 4'd0, 16'h0); serve(3, 1'b0, 20'h00013, 4'd0, 16'h0, 0);
         wait_idle(); set_req(1, 1'b0, 20'h00014, 4'd0, 16'h0); serve(1, 1'b0, 20'h00014, 4'd0, 16'h0, 0);
      end
      wait_idle();
      set_req(2, 1'b0, 20'h00222, 4'd0, 16'h0);
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (ctl.rd_req || ctl.wr_req) seen++;
      end
      check("full_blocked", 64'(seen), 64'd0);
      check("full_idle", 64'(dbg_state), 64'd0);
      ret_word(0, 16'h0F00, 1'b1);
      serve(2, 1'b0, 20'h00222, 4'd0, 16'h0, 0);
      ret_word(1, 16'h0F01, 1'b1);
      ret_word(3, 16'h0F03, 1'b1);
      ret_word(1, 16'h0F11, 1'b1);
      ret_word(2, 16'h0F02, 1'b1);
      settle_and_drain("full_drain");

      // Interleave: port 0 receives a 16-word burst while port 3's write is arbitrated and issued.
      wait_idle();
      snap_acks();
      set_req(0, 1'b0, 20'h04000, 4'd15, 16'h0);
      serve(0, 1'b0, 20'h04000, 4'd15, 16'h0, 0);
      fork
         begin
            for (int k = 0; k < 16; k++) ret_word(0, 16'hC000 + 16'(k), 1'b1);
         end
         begin
            repeat (2) begin
               @(posedge clk); #1;
            end
            set_req(3, 1'b1, 20'h07777, 4'd2, 16'h7777);
            serve(3, 1'b1, 20'h07777, 4'd2, 16'h7777, 1);
         end
      join
      settle_and_drain("ilv_drain");
      check_acks(4'b1001);

      // Error: read data with no outstanding tag.
      wait_idle();
      check("err_before", 64'(tag_err), 64'd0);
      ret_word(0, 16'hDEAD, 1'b0);
      check("err_set", 64'(tag_err), 64'd1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("err_sticky", 64'(tag_err), 64'd1);
      check("err_dropped", 64'(p_rdata), 64'hC00F);

      // Reset during ISSUE with two tags pending.
      wait_idle(); set_req(1, 1'b0, 20'h00501, 4'd0, 16'h0); serve(1, 1'b0, 20'h00501, 4'd0, 16'h0, 0);
      wait_idle(); set_req(2, 1'b0, 20'h00502, 4'd2, 16'h0); serve(2, 1'b0, 20'h00502, 4'd2, 16'h0, 0);
      wait_idle();
      set_req(3, 1'b0, 20'h00503, 4'd1, 16'h0);
      @(posedge clk); #1;
      check("rst2_in_issue", 64'(dbg_state), 64'd1);
      reset_n = 1'b0;
      p_req   = '0;
      #1;
      check("rst2_state",   64'(dbg_state), 64'd0);
      check("rst2_reqs",    64'({ctl.rd_req, ctl.wr_req}), 64'd0);
      check("rst2_strobes", 64'({p_ack, p_rdy}), 64'd0);
      check("rst2_rdata",   64'(p_rdata), 64'd0);
      check("rst2_tag_err", 64'(tag_err), 64'd0);
      check("rst2_ctl_bus", 64'({ctl.rd_addr, ctl.rd_len, ctl.wr_addr, ctl.wr_len}), 64'd0);
      check("rst2_wdata",   64'(ctl.wr_data), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      wait_idle();
      set_req(0, 1'b0, 20'h00042, 4'd1, 16'h0);
      serve(0, 1'b0, 20'h00042, 4'd1, 16'h0, 0);
      ret_word(0, 16'h4200, 1'b1);
      ret_word(0, 16'h4201, 1'b1);
      settle_and_drain("rst2_drain");
      check("rst2_no_err", 64'(tag_err), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
